// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding, default width and counter sizing for seq_divider.
package div_pkg;
  localparam int DEF_WIDTH = 32;
  function automatic int cnt_w(int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
  localparam int CNT_W = cnt_w(DEF_WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/div_addsub.sv
// div_addsub: WIDTH+1-bit adder/subtractor shared by the iteration and remainder fix-up.
module div_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);
  assign sum = sub ? a - b : a + b;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential non-restoring divider, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN to honour signed_op (two's complement operands).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r, q, d, a_mag, b_mag, rem_u, q_fix, r_fix;
  logic [WIDTH:0] r, a_in, sum;
  logic [CW-1:0] cnt;
  logic sub;
  always_comb begin
    nxt = state == IDLE ? (start ? PREP : IDLE) :
          state == PREP ? (b_r == '0 ? FIX : ITER) :
          state == ITER ? (cnt == '0 ? FIX : ITER) :
          state == FIX  ? DONE : IDLE;
  end
  // ITER shifts the next dividend bit in; FIX adds the divisor back to a negative remainder
  assign a_in  = state == ITER ? {r[WIDTH-1:0], q[WIDTH-1]} : r;
  assign sub   = state == ITER && !r[WIDTH];
  assign rem_u = r[WIDTH] ? sum[WIDTH-1:0] : r[WIDTH-1:0];
  div_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (a_in),
    .b   ({1'b0, d}),
    .sub (sub),
    .sum (sum)
  );
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sgn, neg_q, neg_r;
  assign a_mag = sgn && a_r[WIDTH-1] ? -a_r : a_r;
  assign b_mag = sgn && b_r[WIDTH-1] ? -b_r : b_r;
  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -rem_u : rem_u;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_mag = a_r;
  assign b_mag = b_r;
  assign q_fix = q;
  assign r_fix = rem_u;
`endif
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      q           <= '0;
      d           <= '0;
      r           <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sgn         <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state <= nxt;
      busy  <= nxt != IDLE;
      done  <= state == DONE;
      if (state == IDLE && start) begin
        a_r <= dividend;
        b_r <= divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgn <= signed_op;
`endif
      end
      if (state == PREP) begin
        q   <= a_mag;
        d   <= b_mag;
        r   <= '0;
        cnt <= CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_q <= sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
        neg_r <= sgn & a_r[WIDTH-1];
`endif
      end
      if (state == ITER) begin
        r   <= sum;
        q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
        cnt <= cnt - CW'(1);
      end
      if (state == FIX) begin
        quotient    <= d == '0 ? '1 : q_fix;
        remainder   <= d == '0 ? a_r : r_fix;
        div_by_zero <= d == '0;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a scoreboard queue checked by a done monitor.
module tb_seq_divider;
  localparam int W = 32;
  logic clk = 1'b0, clr_n = 1'b0, start = 1'b0, signed_op = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           t;
    int           lat;
  } exp_t;
  exp_t sb[$];
  exp_t m;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", W'(done), '0);
      else begin
        m = sb.pop_front();
        chk("quotient", quotient, m.q);
        chk("remainder", remainder, m.r);
        chk("div_by_zero", W'(div_by_zero), W'(m.dz));
        chk("latency", W'(cyc - m.t), W'(m.lat));
      end
    end
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic push,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz, input int lat);
    exp_t e;
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.t = cyc + 1; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    signed_op = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < bound);
    if (done !== 1'b1) chk("done_timeout", W'(done), W'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_dz", W'(div_by_zero), '0);
    clr_n = 1'b1;
    go(100, 7, 1'b0, 1'b1, 14, 2, 1'b0, 35);
    wait_done(60);
    go(32'hFFFF_FFFF, 1, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 35);
    wait_done(60);
    go(5, 9, 1'b0, 1'b1, 0, 5, 1'b0, 35);
    wait_done(60);
    go(1234, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1234, 1'b1, 3);
    wait_done(60);
`ifdef SEQ_DIVIDER_SIGNED_EN
    go(32'hFFFF_FFF9, 2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35);
    wait_done(60);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 0, 1'b0, 35);
    wait_done(60);
`else
    go(32'hFFFF_FFF9, 2, 1'b1, 1'b1, 32'h7FFF_FFFC, 1, 1'b0, 35);
    wait_done(60);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 32'h8000_0000, 1'b0, 35);
    wait_done(60);
`endif
    go(32'hFFFF_FFF9, 2, 1'b0, 1'b1, 32'h7FFF_FFFC, 1, 1'b0, 35);
    wait_done(60);
    repeat (3) @(negedge clk);
    go(1000, 33, 1'b0, 1'b1, 30, 10, 1'b0, 35);
    repeat (9) @(negedge clk);
    chk("busy_mid_op", W'(busy), W'(1));
    dividend = 1;
    divisor = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60);
    repeat (40) @(negedge clk);
    go(100, 7, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    repeat (16) @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_quotient", quotient, '0);
    chk("arst_remainder", remainder, '0);
    chk("arst_dz", W'(div_by_zero), '0);
    @(negedge clk);
    chk("arst_done", W'(done), '0);
    clr_n = 1'b1;
    repeat (50) @(negedge clk);
    go(100, 7, 1'b0, 1'b1, 14, 2, 1'b0, 35);
    wait_done(60);
    repeat (5) @(negedge clk);
    chk("queue_empty", W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
